// File: rtl/fpu_op_issuer.sv
// Issues buffered floating-point requests one at a time to an FPU op block and
// returns tagged results; rejects unknown opcodes and latches a sticky fault on timeout.
module fpu_op_issuer #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             Clock_i,
  input  logic             Reset_i,
  input  logic             ReqValid_i,
  output logic             ReqReady_o,
  input  logic [7:0]       ReqOp_i,
  input  logic [31:0]      ReqLhs_i,
  input  logic [31:0]      ReqRhs_i,
  input  logic [TAG_W-1:0] ReqTag_i,
  output logic             RspValid_o,
  input  logic             RspReady_i,
  output logic [31:0]      RspResult_o,
  output logic [TAG_W-1:0] RspTag_o,
  output logic             RspError_o,
  output logic             FpuTrigger_o,
  input  logic             FpuCompleted_i,
  output logic [7:0]       FpuOp_o,
  output logic [31:0]      FpuLhs_o,
  output logic [31:0]      FpuRhs_o,
  input  logic [31:0]      FpuResult_i,
  output logic             Fault_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FAULT} state_t;

  logic [7:0]       op_mem  [DEPTH];
  logic [31:0]      lhs_mem [DEPTH];
  logic [31:0]      rhs_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_idx;
  logic             empty, full, push, pop, head_ok, timeout_hit;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             trig_q, fault_q;
  logic [7:0]       fpu_op_q;
  logic [31:0]      fpu_lhs_q, fpu_rhs_q;
  logic             rsp_valid_q, rsp_error_q;
  logic [31:0]      rsp_result_q;
  logic [TAG_W-1:0] rsp_tag_q;

  assign rd_idx      = rd_ptr_q[AW-1:0];
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Held low while reset is asserted so every output reads 0 until release.
  assign ReqReady_o  = !full && !fault_q && !Reset_i;
  assign push        = ReqValid_i && ReqReady_o;
  assign head_ok     = (op_mem[rd_idx] < 8'd4);
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  // Pops mirror the FSM's retire decisions: a rejected opcode or a finished/timed-out op.
  assign pop = ((state_q == S_IDLE) && !empty && !rsp_valid_q && !head_ok) ||
               ((state_q == S_WAIT) && (FpuCompleted_i || timeout_hit));

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

  always_ff @(posedge Clock_i) begin
    if (push) begin
      op_mem[wr_ptr_q[AW-1:0]]  <= ReqOp_i;
      lhs_mem[wr_ptr_q[AW-1:0]] <= ReqLhs_i;
      rhs_mem[wr_ptr_q[AW-1:0]] <= ReqRhs_i;
      tag_mem[wr_ptr_q[AW-1:0]] <= ReqTag_i;
    end
  end

  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      trig_q       <= 1'b0;
      fault_q      <= 1'b0;
      fpu_op_q     <= '0;
      fpu_lhs_q    <= '0;
      fpu_rhs_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_error_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
    end else begin
      trig_q <= 1'b0;
      if (rsp_valid_q && RspReady_i) rsp_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (!empty && !rsp_valid_q) begin
            if (head_ok) begin
              fpu_op_q  <= op_mem[rd_idx];
              fpu_lhs_q <= lhs_mem[rd_idx];
              fpu_rhs_q <= rhs_mem[rd_idx];
              trig_q    <= 1'b1;
              state_q   <= S_ISSUE;
            end else begin
              rsp_valid_q  <= 1'b1;
              rsp_result_q <= '0;
              rsp_tag_q    <= tag_mem[rd_idx];
              rsp_error_q  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A completion in the timeout cycle still wins.
          if (FpuCompleted_i) begin
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= FpuResult_i;
            rsp_tag_q    <= tag_mem[rd_idx];
            rsp_error_q  <= 1'b0;
            state_q      <= S_IDLE;
          end else if (timeout_hit) begin
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= '0;
            rsp_tag_q    <= tag_mem[rd_idx];
            rsp_error_q  <= 1'b1;
            fault_q      <= 1'b1;
            state_q      <= S_FAULT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign RspValid_o   = rsp_valid_q;
  assign RspResult_o  = rsp_result_q;
  assign RspTag_o     = rsp_tag_q;
  assign RspError_o   = rsp_error_q;
  assign FpuTrigger_o = trig_q;
  assign FpuOp_o      = fpu_op_q;
  assign FpuLhs_o     = fpu_lhs_q;
  assign FpuRhs_o     = fpu_rhs_q;
  assign Fault_o      = fault_q;

endmodule

// File: tb/tb_fpu_op_issuer.sv
// Scoreboard bench for fpu_op_issuer: FPU stub, randomized client traffic, and
// directed add / ordering / invalid-op / backpressure / timeout / reset scenarios.
module tb_fpu_op_issuer;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int TMO   = 16;

  logic             clk = 1'b0;
  logic             Reset;
  logic             ReqValid, ReqReady_o;
  logic [7:0]       ReqOp;
  logic [31:0]      ReqLhs, ReqRhs;
  logic [TAG_W-1:0] ReqTag;
  logic             RspValid_o, RspReady;
  logic [31:0]      RspResult_o;
  logic [TAG_W-1:0] RspTag_o;
  logic             RspError_o, FpuTrigger_o, FpuCompleted;
  logic [7:0]       FpuOp_o;
  logic [31:0]      FpuLhs_o, FpuRhs_o, FpuResult;
  logic             Fault_o;

  fpu_op_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TMO)) dut (
    .Clock_i(clk), .Reset_i(Reset),
    .ReqValid_i(ReqValid), .ReqReady_o(ReqReady_o), .ReqOp_i(ReqOp),
    .ReqLhs_i(ReqLhs), .ReqRhs_i(ReqRhs), .ReqTag_i(ReqTag),
    .RspValid_o(RspValid_o), .RspReady_i(RspReady), .RspResult_o(RspResult_o),
    .RspTag_o(RspTag_o), .RspError_o(RspError_o),
    .FpuTrigger_o(FpuTrigger_o), .FpuCompleted_i(FpuCompleted),
    .FpuOp_o(FpuOp_o), .FpuLhs_o(FpuLhs_o), .FpuRhs_o(FpuRhs_o),
    .FpuResult_i(FpuResult), .Fault_o(Fault_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_t;

  rsp_t exp_q[$];
  int n_checks = 0, n_errors = 0;
  int cyc = 0, acc_cyc = 0, last_trig_cyc = 0, trig_cnt = 0;
  int stub_cnt = -1;
  bit stub_hang = 0;
  int inj_req = 0, inj_done = 0;
  bit rdy_rand = 0, rdy_force = 1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference arithmetic through double precision; operands are kept normal.
  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == 31'd0) d = {s[31], 63'd0};
    else d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    real x, y, r;
    x = s2r(a);
    y = s2r(b);
    case (op)
      8'd0:    r = x + y;
      8'd1:    r = x - y;
      8'd2:    r = x * y;
      default: r = x / y;
    endcase
    return r2s(r);
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    e = 8'($urandom_range(120, 134));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // Response-port readiness driver.
  initial begin
    RspReady = 1'b1;
    forever begin
      @(negedge clk);
      RspReady = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // FPU op block stub: completes 1..4 cycles after a trigger unless hung.
  logic [7:0]  t_op;
  logic [31:0] t_lhs, t_rhs, stub_res;
  initial begin
    FpuCompleted = 1'b0;
    FpuResult = '0;
    forever begin
      @(negedge clk);
      FpuCompleted = 1'b0;
      FpuResult = $urandom;
      if (Reset) begin
        stub_cnt = -1;
        continue;
      end
      if (inj_done != inj_req) begin
        inj_done = inj_req;
        FpuCompleted = 1'b1;
      end else if (stub_cnt == 0) begin
        chk("fpu_op_held", FpuOp_o, t_op);
        chk("fpu_operands_held", {FpuLhs_o, FpuRhs_o}, {t_lhs, t_rhs});
        FpuCompleted = 1'b1;
        FpuResult = stub_res;
        stub_cnt = -1;
      end else if (stub_cnt > 0) begin
        stub_cnt--;
      end
      if (FpuTrigger_o) begin
        trig_cnt++;
        last_trig_cyc = cyc;
        chk("trigger_while_busy", (stub_cnt != -1), 0);
        chk("trigger_op_supported", (FpuOp_o >= 8'd4), 0);
        t_op = FpuOp_o;
        t_lhs = FpuLhs_o;
        t_rhs = FpuRhs_o;
        stub_res = fp_model(FpuOp_o, FpuLhs_o, FpuRhs_o);
        stub_cnt = stub_hang ? -2 : $urandom_range(0, 3);
      end
    end
  end

  // Monitor: compare every accepted response against the scoreboard head.
  initial forever begin
    rsp_t e;
    @(negedge clk);
    #2;
    if (!Reset && RspValid_o && RspReady) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rsp_unexpected: got result %0h tag %0h err %0b, required none", RspResult_o, RspTag_o, RspError_o);
      end else begin
        e = exp_q.pop_front();
        chk("rsp", {RspResult_o, RspTag_o, RspError_o}, {e.res, e.tag, e.err});
      end
    end
  end

  task automatic send(input logic [7:0] op, input logic [31:0] l, input logic [31:0] r,
                      input logic [TAG_W-1:0] t, input bit use_exp,
                      input logic [31:0] eres, input bit eerr);
    rsp_t e;
    bit done;
    done = 0;
    @(negedge clk);
    ReqValid = 1'b1; ReqOp = op; ReqLhs = l; ReqRhs = r; ReqTag = t;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (ReqReady_o) begin
        acc_cyc = cyc;
        e.tag = t;
        if (use_exp) begin
          e.res = eres; e.err = eerr;
        end else if (op < 8'd4 && !stub_hang) begin
          e.res = fp_model(op, l, r); e.err = 1'b0;
        end else begin
          e.res = '0; e.err = 1'b1;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        done = 1;
        break;
      end
      @(negedge clk);
    end
    ReqValid = 1'b0;
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL req_accept_timeout: got ReqReady=0 for 200 cycles, required 1");
    end
  endtask

  task automatic wait_trig(input int target);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (trig_cnt >= target) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL trigger_wait_timeout: got %0d triggers, required %0d", trig_cnt, target);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    n_checks++;
    n_errors++;
    $display("FAIL drain_timeout: got %0d responses outstanding, required 0", exp_q.size());
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int t0, nvalid, tt, rv;
    logic [7:0] op;
    Reset = 1'b1; ReqValid = 1'b0; ReqOp = '0; ReqLhs = '0; ReqRhs = '0; ReqTag = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl_outs", {ReqReady_o, RspValid_o, RspError_o, FpuTrigger_o, Fault_o, RspTag_o, RspResult_o}, 0);
    chk("reset_fpu_op_lhs", {FpuOp_o, FpuLhs_o}, 0);
    chk("reset_fpu_rhs", FpuRhs_o, 0);
    Reset = 1'b0;
    #1 chk("ready_after_reset", ReqReady_o, 1);

    // Single add with issue latency
    rdy_force = 1;
    t0 = trig_cnt;
    send(8'd0, 32'h3F800000, 32'h40000000, 4'd1, 1, 32'h40400000, 0);
    wait_trig(t0 + 1);
    chk("add_issue_latency", last_trig_cyc - acc_cyc, 2);
    wait_drain();

    // Back-to-back in-order queue
    t0 = trig_cnt;
    send(8'd1, 32'h40400000, 32'h3F800000, 4'd2, 1, 32'h40000000, 0);
    send(8'd2, 32'h40000000, 32'h40400000, 4'd3, 1, 32'h40C00000, 0);
    send(8'd3, 32'h40C00000, 32'h40000000, 4'd4, 1, 32'h40400000, 0);
    wait_drain();
    repeat (5) @(negedge clk);
    chk("inorder_trigger_count", trig_cnt - t0, 3);

    // Invalid opcode then fill the FIFO behind an untaken response
    rdy_force = 0;
    repeat (2) @(negedge clk);
    t0 = trig_cnt;
    send(8'd7, 32'h12345678, 32'h9ABCDEF0, 4'd5, 1, 32'h0, 1);
    repeat (3) @(negedge clk);
    #1 chk("invalid_rsp_pending", RspValid_o, 1);
    for (int i = 0; i < DEPTH; i++)
      send(8'($urandom_range(0, 3)), rand_fp(), rand_fp(), 4'($urandom_range(0, 15)), 0, 0, 0);
    @(negedge clk);
    #1 chk("full_drops_ready", ReqReady_o, 0);
    repeat (5) @(negedge clk);
    chk("no_issue_while_slot_full", trig_cnt - t0, 0);
    rdy_rand = 1;
    wait_drain();
    repeat (10) @(negedge clk);
    chk("backpressure_trigger_count", trig_cnt - t0, DEPTH);

    // Randomized traffic
    t0 = trig_cnt;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(4, 255));
      if (op < 8'd4) nvalid++;
      send(op, rand_fp(), rand_fp(), 4'($urandom_range(0, 15)), 0, 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain();
    repeat (10) @(negedge clk);
    chk("random_trigger_count", trig_cnt - t0, nvalid);

    // Watchdog timeout with a hung FPU
    rdy_rand = 0;
    rdy_force = 0;
    stub_hang = 1;
    repeat (2) @(negedge clk);
    t0 = trig_cnt;
    send(8'd0, rand_fp(), rand_fp(), 4'd9, 1, 32'h0, 1);
    wait_trig(t0 + 1);
    tt = last_trig_cyc;
    rv = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (RspValid_o) begin
        rv = cyc;
        break;
      end
    end
    chk("timeout_rsp_cycle", rv - tt, TMO + 1);
    chk("fault_set", Fault_o, 1);
    chk("fault_not_ready", ReqReady_o, 0);
    inj_req++;
    repeat (6) @(negedge clk);
    #1 chk("late_completion_ignored", {RspValid_o, RspError_o, RspResult_o}, {1'b1, 1'b1, 32'h0});
    chk("no_issue_in_fault", trig_cnt - t0, 1);
    rdy_force = 1;
    wait_drain();
    repeat (4) @(negedge clk);
    #1 chk("no_extra_rsp_after_fault", RspValid_o, 0);
    chk("fault_sticky", {Fault_o, ReqReady_o}, {1'b1, 1'b0});

    // Asynchronous reset in the middle of WAIT
    @(negedge clk);
    #1 Reset = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    #1 Reset = 1'b0;
    t0 = trig_cnt;
    send(8'd2, 32'h40000000, 32'h40400000, 4'd3, 1, 32'h0, 1);
    wait_trig(t0 + 1);
    repeat (3) @(negedge clk);
    #2 Reset = 1'b1;
    #1;
    chk("midwait_reset_ctrl_outs", {ReqReady_o, RspValid_o, RspError_o, FpuTrigger_o, Fault_o, RspTag_o, RspResult_o}, 0);
    chk("midwait_reset_fpu_op_lhs", {FpuOp_o, FpuLhs_o}, 0);
    chk("midwait_reset_fpu_rhs", FpuRhs_o, 0);
    exp_q.delete();
    stub_hang = 0;
    repeat (2) @(negedge clk);
    #1 Reset = 1'b0;
    #1 chk("ready_after_midwait_reset", ReqReady_o, 1);
    t0 = trig_cnt;
    repeat (5) @(negedge clk);
    chk("fifo_empty_after_reset", {trig_cnt - t0, 31'd0, RspValid_o}, 0);
    send(8'd0, 32'h3F800000, 32'h40000000, 4'd6, 1, 32'h40400000, 0);
    wait_trig(t0 + 1);
    chk("post_reset_issue_latency", last_trig_cyc - acc_cyc, 2);
    wait_drain();
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
